// File: rtl/turn_event_gen_if.sv
// ---------------------------------------------------------------------------
// turn_event_gen_if
//   Signal bundle between the game turn controller and its event responder
//   (turn_event_gen).
//
//   Signals:
//     start_turn    controller -> responder  timer-start phase (level)
//     player_turn   controller -> responder  player-turn phase (level)
//     pc_turn       controller -> responder  PC-turn phase (level)
//     move_btn      board      -> responder  raw confirm button, async to clk
//     player_done   responder  -> controller one-cycle pulse, move confirmed
//     turn_timeout  responder  -> controller one-cycle pulse, time expired
//     pc_done       responder  -> controller one-cycle pulse, PC delay done
//     secs_left     responder  -> display    seconds remaining (5 bits)
//     counting      responder  -> display    high while countdown runs
//     state         responder  -> debug      current FSM state encoding
//
//   Handshake: there is no valid/ready pairing on this bundle. Phase inputs
//   are levels the controller holds for as long as the phase lasts; the three
//   event outputs are single-cycle registered pulses that the controller
//   samples on the next clk edge and that are never high two cycles in a row.
//
//   Modports: master = controller side, slave = turn_event_gen.
// ---------------------------------------------------------------------------
interface turn_event_gen_if;
  logic       start_turn;
  logic       player_turn;
  logic       pc_turn;
  logic       move_btn;
  logic       player_done;
  logic       turn_timeout;
  logic       pc_done;
  logic [4:0] secs_left;
  logic       counting;
  logic [1:0] state;

  modport master (
    output start_turn, player_turn, pc_turn, move_btn,
    input  player_done, turn_timeout, pc_done, secs_left, counting, state
  );

  modport slave (
    input  start_turn, player_turn, pc_turn, move_btn,
    output player_done, turn_timeout, pc_done, secs_left, counting, state
  );
endinterface

// File: rtl/turn_event_gen.sv
// ---------------------------------------------------------------------------
// turn_event_gen
//   Responder side of the game turn controller. Watches the controller's
//   phase levels and produces the events its next-state logic waits on:
//   player move confirmed, turn timeout and PC move done. Also drives the
//   remaining-seconds value for the turn display.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   turn_event_gen_if.slave (phase inputs, event pulses, secs_left,
//           counting, debug state)
//
//   Parameters:
//     CLK_HZ           clock cycles per one-second tick
//     TURN_SECS        player turn length in seconds (1..31)
//     PC_DELAY_SECS    PC "thinking" time in seconds (1..15)
//     DEBOUNCE_CYCLES  stable cycles required on move_btn (debounce build)
//
//   Build option:
//     TURN_DEBOUNCE_EN  when defined, the synchronized button goes through a
//                       debouncer before edge detection.
//
//   Timing: move_btn high before edge k gives player_done in the cycle after
//   edge k+3 (two sync flops, the edge flop, the output register); the
//   debounce build adds DEBOUNCE_CYCLES to that.
// ---------------------------------------------------------------------------
module turn_event_gen #(
  parameter int CLK_HZ          = 50000000,
  parameter int TURN_SECS       = 15,
  parameter int PC_DELAY_SECS   = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  turn_event_gen_if.slave  bus
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_HZ - 1);
  localparam logic [4:0]        TURN_LOAD = 5'(TURN_SECS);
  localparam logic [3:0]        PC_LOAD   = 4'(PC_DELAY_SECS);

  // Out-of-range parameters stop elaboration rather than silently truncating.
  if (TURN_SECS < 1 || TURN_SECS > 31 || PC_DELAY_SECS < 1 ||
      PC_DELAY_SECS > 15 || CLK_HZ < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("turn_event_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    HOLD    = 2'd2,
    PC_WAIT = 2'd3
  } state_t;

  state_t            state;
  logic [4:0]        secs_left;
  logic              counting;
  logic              player_done;
  logic              turn_timeout;
  logic              pc_done;
  logic [3:0]        pc_cnt;
  logic [TICK_W-1:0] tick;
  logic              tick_wrap;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic mv_src;    // button level the edge detector looks at
  logic mv_src_d;
  logic mv;        // registered rising edge of mv_src
  logic start_d;
  logic st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.move_btn;
      sync2 <= sync1;
    end
  end

`ifdef TURN_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            filt;
  logic [DB_W-1:0] db_cnt;

  // The filtered level flips on the DEBOUNCE_CYCLES-th consecutive cycle
  // in which sync2 disagrees with it; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 != filt) begin
      if (db_cnt == DB_LAST) begin
        filt   <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign mv_src = filt;
`else
  assign mv_src = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_src_d <= 1'b0;
      mv       <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      mv_src_d <= mv_src;
      mv       <= mv_src & ~mv_src_d;
      start_d  <= bus.start_turn;
    end
  end

  // start_turn comes from the same clock domain, so a plain edge detect is
  // enough and keeps the restart response one cycle after the rise.
  assign st        = bus.start_turn & ~start_d;
  assign tick_wrap = (tick == TICK_MAX);

  // -------------------------------------------------------------------------
  // Turn FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      secs_left    <= '0;
      counting     <= 1'b0;
      player_done  <= 1'b0;
      turn_timeout <= 1'b0;
      pc_done      <= 1'b0;
      pc_cnt       <= '0;
      tick         <= '0;
    end else begin
      player_done  <= 1'b0;
      turn_timeout <= 1'b0;
      pc_done      <= 1'b0;
      tick         <= tick_wrap ? '0 : tick + 1'b1;

      if (st) begin
        // A fresh arm overrides whatever the FSM was doing this cycle.
        state     <= COUNT;
        secs_left <= TURN_LOAD;
        counting  <= 1'b1;
        tick      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.pc_turn) begin
              state  <= PC_WAIT;
              pc_cnt <= PC_LOAD;
              tick   <= '0;
            end
          end

          COUNT: begin
            // The move is checked first so it wins over the expiry tick.
            if (mv && (bus.player_turn || bus.start_turn)) begin
              player_done <= 1'b1;
              state       <= HOLD;
              counting    <= 1'b0;
            end else if (tick_wrap) begin
              if (secs_left > 5'd1) begin
                secs_left <= secs_left - 5'd1;
              end else begin
                secs_left    <= '0;
                turn_timeout <= 1'b1;
                state        <= HOLD;
                counting     <= 1'b0;
              end
            end
          end

          HOLD: begin
            if (bus.pc_turn) begin
              state  <= PC_WAIT;
              pc_cnt <= PC_LOAD;
              tick   <= '0;
            end
          end

          PC_WAIT: begin
            if (!bus.pc_turn) begin
              state <= IDLE;
            end else if (tick_wrap) begin
              if (pc_cnt <= 4'd1) begin
                pc_cnt  <= '0;
                pc_done <= 1'b1;
                state   <= IDLE;
              end else begin
                pc_cnt <= pc_cnt - 4'd1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.player_done  = player_done;
  assign bus.turn_timeout = turn_timeout;
  assign bus.pc_done      = pc_done;
  assign bus.secs_left    = secs_left;
  assign bus.counting     = counting;
  assign bus.state        = state;

endmodule
